// File: rtl/axi_wr_mux2_arbiter.sv
// Round-robin write-channel arbiter for two AXI masters sharing one slave
// port through the AW and W Mux_2x1_en instances. A grant is taken in IDLE,
// held from the AW handshake through the WLAST beat, and released for one
// bubble cycle before the next arbitration. The W beat count is compared
// against the captured AWLEN and a single len_err pulse reports a mismatch.

module axi_wr_mux2_arbiter #(
  parameter int LEN_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             m0_awvalid,
  input  logic             m1_awvalid,
  input  logic             s_awready,
  input  logic [LEN_W-1:0] s_awlen,
  input  logic             s_wvalid,
  input  logic             s_wready,
  input  logic             s_wlast,
  output logic             mux_sel,
  output logic             mux_enable,
  output logic             m0_awready,
  output logic             m1_awready,
  output logic             m0_wready,
  output logic             m1_wready,
  output logic             len_err
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  // Beat counter increment that sticks at the all-ones value.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + LEN_W'(1);
    end
  endfunction

  // Round-robin pick: a lone requester wins, a tie goes to the master
  // that did not win last time.
  function automatic logic arb_pick(input logic req0, input logic req1,
                                    input logic last);
    if (req0 && req1) begin
      arb_pick = ~last;
    end else begin
      arb_pick = req1;
    end
  endfunction

  logic [1:0]       state_r,      state_s;
  logic             mux_sel_r,    mux_sel_s;
  logic             mux_enable_r, mux_enable_s;
  logic             rr_last_r,    rr_last_s;
  logic [LEN_W-1:0] beat_cnt_r,   beat_cnt_s;
  logic [LEN_W-1:0] len_cap_r,    len_cap_s;
  logic             len_err_r,    len_err_s;
  // Set once a burst has reported its length error so it reports only once.
  logic             err_seen_r,   err_seen_s;

  logic             gnt_s;
  logic             aw_hs_s;
  logic             w_hs_s;
  logic             in_addr_s;
  logic             in_data_s;

  assign gnt_s     = arb_pick(m0_awvalid, m1_awvalid, rr_last_r);
  assign aw_hs_s   = (mux_sel_r ? m1_awvalid : m0_awvalid) & s_awready;
  assign w_hs_s    = s_wvalid & s_wready;
  assign in_addr_s = (state_r == ST_ADDR);
  assign in_data_s = (state_r == ST_DATA);

  // Next-state and next-output computation for the grant FSM.
  always_comb begin
    state_s      = state_r;
    mux_sel_s    = mux_sel_r;
    mux_enable_s = mux_enable_r;
    rr_last_s    = rr_last_r;
    beat_cnt_s   = beat_cnt_r;
    len_cap_s    = len_cap_r;
    len_err_s    = 1'b0;
    err_seen_s   = err_seen_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_awvalid || m1_awvalid) begin
          state_s      = ST_ADDR;
          mux_sel_s    = gnt_s;
          mux_enable_s = 1'b1;
          rr_last_s    = gnt_s;
        end else begin
          state_s      = ST_IDLE;
          mux_enable_s = 1'b0;
        end
      end
      ST_ADDR: begin
        if (aw_hs_s) begin
          state_s    = ST_DATA;
          len_cap_s  = s_awlen;
          beat_cnt_s = '0;
          err_seen_s = 1'b0;
        end else begin
          state_s    = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (w_hs_s) begin
          beat_cnt_s = sat_inc(beat_cnt_r);
          if (s_wlast) begin
            // beat_cnt_r is the count before this beat, i.e. AWLEN on a
            // correctly sized burst.
            state_s      = ST_IDLE;
            mux_enable_s = 1'b0;
            len_err_s    = (beat_cnt_r != len_cap_r) & ~err_seen_r;
          end else if ((beat_cnt_r == len_cap_r) && !err_seen_r) begin
            // The beat that should have carried WLAST did not.
            len_err_s  = 1'b1;
            err_seen_s = 1'b1;
          end else begin
            len_err_s  = 1'b0;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        mux_enable_s = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r      <= ST_IDLE;
      mux_sel_r    <= 1'b0;
      mux_enable_r <= 1'b0;
      rr_last_r    <= 1'b1;
      beat_cnt_r   <= '0;
      len_cap_r    <= '0;
      len_err_r    <= 1'b0;
      err_seen_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      mux_sel_r    <= mux_sel_s;
      mux_enable_r <= mux_enable_s;
      rr_last_r    <= rr_last_s;
      beat_cnt_r   <= beat_cnt_s;
      len_cap_r    <= len_cap_s;
      len_err_r    <= len_err_s;
      err_seen_r   <= err_seen_s;
    end
  end

  assign mux_sel    = mux_sel_r;
  assign mux_enable = mux_enable_r;
  assign len_err    = len_err_r;

  assign m0_awready = mux_enable_r & ~mux_sel_r & s_awready & in_addr_s;
  assign m1_awready = mux_enable_r &  mux_sel_r & s_awready & in_addr_s;
  assign m0_wready  = mux_enable_r & ~mux_sel_r & s_wready  & in_data_s;
  assign m1_wready  = mux_enable_r &  mux_sel_r & s_wready  & in_data_s;

  axi_wr_mux2_arbiter_chk u_chk (
    .clk        (ACLK),
    .aresetn    (ARESETN),
    .state      (state_r),
    .mux_enable (mux_enable_r),
    .readys     ({m1_wready, m0_wready, m1_awready, m0_awready})
  );

endmodule

// Structural invariants of the arbiter.
module axi_wr_mux2_arbiter_chk (
  input logic       clk,
  input logic       aresetn,
  input logic [1:0] state,
  input logic       mux_enable,
  input logic [3:0] readys
);

  a_state_legal: assert property (@(posedge clk) disable iff (!aresetn)
    state != 2'b11);

  a_enable_matches_state: assert property (@(posedge clk) disable iff (!aresetn)
    mux_enable == (state != 2'b00));

  a_single_ready: assert property (@(posedge clk) disable iff (!aresetn)
    $onehot0(readys));

endmodule

// File: tb/tb_axi_wr_mux2_arbiter.sv
// Randomised and directed bench for axi_wr_mux2_arbiter. Two master drivers
// and a slave model feed a behavioural Mux_2x1_en; a monitor tracks bursts at
// transaction level and compares the DUT against the arbitration rules.
`timescale 1ns/1ps

module tb_axi_wr_mux2_arbiter;

  typedef struct { int len; int nb; }              plan_t;
  typedef struct { int len; int nb; int err_beat; } exp_t;

  logic       clk = 1'b0;
  logic       ARESETN;
  logic [1:0] drv_awv, dir_awv, wv, wl;
  logic [7:0] awl [2];
  logic       s_awready, s_wready;
  wire  [1:0] awvalid = drv_awv | dir_awv;
  wire  [7:0] s_awlen;
  wire        s_wvalid, s_wlast;
  wire        mux_sel, mux_enable, len_err;
  wire        m0_awready, m1_awready, m0_wready, m1_wready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural Mux_2x1_en: outputs forced low when disabled.
  assign s_awlen  = mux_enable ? (mux_sel ? awl[1] : awl[0]) : 8'd0;
  assign s_wvalid = mux_enable & (mux_sel ? wv[1] : wv[0]);
  assign s_wlast  = mux_enable & (mux_sel ? wl[1] : wl[0]);

  axi_wr_mux2_arbiter #(.LEN_W(8)) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .m0_awvalid(awvalid[0]), .m1_awvalid(awvalid[1]),
    .s_awready(s_awready), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .mux_sel(mux_sel), .mux_enable(mux_enable),
    .m0_awready(m0_awready), .m1_awready(m1_awready),
    .m0_wready(m0_wready), .m1_wready(m1_wready),
    .len_err(len_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: a lone requester wins, a tie goes to the master that did not
  // win the previous arbitration.
  function automatic int pick(input logic [1:0] req, input int last);
    if (req == 2'b01) return 0;
    else if (req == 2'b10) return 1;
    else return (last == 0) ? 1 : 0;
  endfunction

  // Error position from the burst shape: an overrun flags at beat AWLEN+1,
  // an underrun at the WLAST beat, a correct burst never.
  function automatic int err_beat_of(input int len, input int nb);
    if (nb == len + 1) return 0;
    else if (nb > len + 1) return len + 1;
    else return nb;
  endfunction

  plan_t plan_q [2][$];
  exp_t  exp_q  [2][$];
  bit    rnd_mode;
  int    slave_mode;

  task automatic add_plan(input int m, input int len, input int nb);
    plan_t p;
    p.len = len;
    p.nb  = nb;
    plan_q[m].push_back(p);
  endtask

  // ---------------- slave ready model ----------------
  initial begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (slave_mode)
        0: begin s_awready = 1'b0; s_wready = 1'b0; end
        1: begin s_awready = 1'b1; s_wready = 1'b1; end
        default: begin
          s_awready = ($urandom_range(0, 3) != 0);
          s_wready  = ($urandom_range(0, 3) != 0);
        end
      endcase
    end
  end

  // ---------------- master drivers ----------------
  int    dph [2];
  int    dbeat [2];
  int    dwait [2];
  plan_t dplan [2];
  logic [1:0] aw_hs_d, w_hs_d;

  function automatic logic draw_valid();
    return rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  initial begin
    exp_t e;
    drv_awv = 2'b00; wv = 2'b00; wl = 2'b00;
    awl[0] = 8'd0; awl[1] = 8'd0;
    for (int m = 0; m < 2; m++) begin dph[m] = 0; dbeat[m] = 0; dwait[m] = 0; end
    forever begin
      @(negedge clk);
      aw_hs_d = drv_awv & {m1_awready, m0_awready};
      w_hs_d  = wv & {m1_wready, m0_wready};
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (!ARESETN) begin
          dph[m] = 0; drv_awv[m] = 1'b0; wv[m] = 1'b0; wl[m] = 1'b0;
        end else begin
          if (dph[m] == 1) begin
            dwait[m]++;
            if (aw_hs_d[m]) begin
              drv_awv[m] = 1'b0; dph[m] = 2; dbeat[m] = 0; dwait[m] = 0;
              wv[m] = draw_valid(); wl[m] = (dplan[m].nb == 1);
            end else if (dwait[m] > 3000) begin
              chk("aw_wait_cycles", dwait[m], 3000);
              drv_awv[m] = 1'b0; dph[m] = 0;
            end
          end else if (dph[m] == 2) begin
            dwait[m]++;
            if (w_hs_d[m]) begin
              dbeat[m]++; dwait[m] = 0;
              if (dbeat[m] == dplan[m].nb) begin
                wv[m] = 1'b0; wl[m] = 1'b0; dph[m] = 0;
              end else begin
                wv[m] = draw_valid(); wl[m] = (dbeat[m] + 1 == dplan[m].nb);
              end
            end else if (dwait[m] > 3000) begin
              chk("w_wait_cycles", dwait[m], 3000);
              wv[m] = 1'b0; wl[m] = 1'b0; dph[m] = 0;
            end else if (!wv[m]) begin
              wv[m] = draw_valid();
            end
          end
          if (dph[m] == 0 && plan_q[m].size() > 0) begin
            dplan[m]   = plan_q[m].pop_front();
            e.len      = dplan[m].len;
            e.nb       = dplan[m].nb;
            e.err_beat = err_beat_of(e.len, e.nb);
            exp_q[m].push_back(e);
            drv_awv[m] = 1'b1;
            awl[m]     = 8'(dplan[m].len);
            dph[m]     = 1;
            dwait[m]   = 0;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   ph_m = 0;        // 0 idle, 1 address phase, 2 data phase
  int   sel_m = 0;
  int   last_win = 1;
  int   mon_beats = 0;
  int   err_cnt = 0;
  bit   pend_err = 1'b0;
  bit   prev_rst_low = 1'b1;
  exp_t cur;
  int   grant_log [$];

  initial begin
    int w;
    cur.len = 0; cur.nb = 0; cur.err_beat = 0;
    forever begin
      @(negedge clk);
      if (prev_rst_low) begin
        chk("rst_mux_enable", int'(mux_enable), 0);
        chk("rst_mux_sel",    int'(mux_sel), 0);
        chk("rst_len_err",    int'(len_err), 0);
        chk("rst_readys", int'({m1_wready, m0_wready, m1_awready, m0_awready}), 0);
        ph_m = 0; sel_m = 0; last_win = 1; pend_err = 1'b0;
      end else begin
        chk("mux_enable", int'(mux_enable), int'(ph_m != 0));
        chk("mux_sel",    int'(mux_sel), sel_m);
        chk("len_err",    int'(len_err), int'(pend_err));
        chk("m0_awready", int'(m0_awready), int'(ph_m == 1 && sel_m == 0 && s_awready));
        chk("m1_awready", int'(m1_awready), int'(ph_m == 1 && sel_m == 1 && s_awready));
        chk("m0_wready",  int'(m0_wready),  int'(ph_m == 2 && sel_m == 0 && s_wready));
        chk("m1_wready",  int'(m1_wready),  int'(ph_m == 2 && sel_m == 1 && s_wready));
      end
      if (len_err) err_cnt++;
      pend_err = 1'b0;
      if (!ARESETN) begin
        exp_q[0].delete(); exp_q[1].delete();
        ph_m = 0; sel_m = 0; last_win = 1;
      end else begin
        case (ph_m)
          0: if (awvalid != 2'b00) begin
               w = pick(awvalid, last_win);
               sel_m = w; last_win = w; ph_m = 1;
               grant_log.push_back(w);
             end
          1: if (awvalid[sel_m] && s_awready) begin
               chk("aw_planned", int'(exp_q[sel_m].size()), 1);
               if (exp_q[sel_m].size() > 0) cur = exp_q[sel_m].pop_front();
               mon_beats = 0; ph_m = 2;
             end
          default: if (s_wvalid && s_wready) begin
               mon_beats++;
               if (mon_beats == cur.err_beat) pend_err = 1'b1;
               if (s_wlast) ph_m = 0;
             end
        endcase
      end
      prev_rst_low = !ARESETN;
    end
  end

  // Wait until every planned burst has completed, then let trailing pulses land.
  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #2;
      done = (plan_q[0].size() == 0) && (plan_q[1].size() == 0) &&
             (dph[0] == 0) && (dph[1] == 0) && (ph_m == 0);
    end
    chk("idle_reached", int'(done), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog cycles=50000 limit=50000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base, exp_errs, len, nb, r;
    bit hit;
    ARESETN = 1'b0; dir_awv = 2'b11; slave_mode = 0; rnd_mode = 1'b0;

    // 1: reset with both requesting, then release: master 0 wins first.
    repeat (2) @(posedge clk);
    #2 ARESETN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_grant_enable", int'(mux_enable), 1);
    chk("t1_grant_sel",    int'(mux_sel), 0);
    @(posedge clk); #2;
    dir_awv = 2'b00; ARESETN = 1'b0;
    repeat (2) @(posedge clk);
    #2 ARESETN = 1'b1; slave_mode = 1;

    // 2: single AWLEN=3 burst from master 1.
    base = err_cnt;
    add_plan(1, 3, 4);
    wait_idle(500);
    chk("t2_len_err_pulses", err_cnt - base, 0);

    // 3: continuous single-beat requests from both masters alternate.
    grant_log.delete();
    add_plan(0, 0, 1); add_plan(0, 0, 1);
    add_plan(1, 0, 1); add_plan(1, 0, 1);
    wait_idle(500);
    chk("t3_grant_count", int'(grant_log.size()), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("t3_grant%0d", i), grant_log[i], i % 2);

    // 4: short burst.
    base = err_cnt;
    add_plan(0, 3, 2);
    wait_idle(500);
    chk("t4_len_err_pulses", err_cnt - base, 1);

    // 5: long burst, exactly one pulse.
    base = err_cnt;
    add_plan(1, 1, 3);
    wait_idle(500);
    chk("t5_len_err_pulses", err_cnt - base, 1);

    // 6: reset after beat 1 of an AWLEN=7 burst from master 0.
    base = err_cnt;
    add_plan(0, 7, 8);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #2;
      hit = (ph_m == 2) && (mon_beats >= 1);
    end
    chk("t6_beat1_seen", int'(hit), 1);
    ARESETN = 1'b0;
    repeat (2) @(posedge clk);
    #2 ARESETN = 1'b1;
    @(posedge clk); #2;
    chk("t6_no_len_err", err_cnt - base, 0);
    grant_log.delete();
    add_plan(0, 0, 1); add_plan(1, 0, 1);
    wait_idle(500);
    chk("t6_regrant_count", int'(grant_log.size()), 2);
    if (grant_log.size() > 0) chk("t6_first_grant", grant_log[0], 0);

    // Random traffic with throttled valids/readys and mixed burst shapes.
    rnd_mode = 1'b1; slave_mode = 2;
    base = err_cnt; exp_errs = 0;
    for (int i = 0; i < 60; i++) begin
      len = $urandom_range(0, 5);
      r   = $urandom_range(0, 5);
      if (r == 0) nb = len + 2;
      else if (r == 1 && len > 0) nb = len;
      else nb = len + 1;
      if (nb != len + 1) exp_errs++;
      add_plan(i % 2 == 0 ? 0 : $urandom_range(0, 1), len, nb);
    end
    wait_idle(20000);
    chk("rand_len_err_pulses", err_cnt - base, exp_errs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_mux2_arbiter.md
Name: axi_wr_mux2_arbiter

Overview:
- Round-robin write-channel arbiter for two AXI masters sharing one slave port through the AW and W instances of Mux_2x1_en.
- Drives the mux `sel` and `enable`, gates AWREADY and WREADY back to the masters, and holds a grant from AW handshake through the WLAST beat.
- Checks that the W beat count matches the captured AWLEN.
- Sits in the interconnect datapath between the master-side ports and the mux instances.

Parameters:
- LEN_W, 8, width of AWLEN and of the internal beat counter.

Ports:
- ACLK  input  1  clock; all state updates on the rising edge.
- ARESETN  input  1  synchronous active-low reset.
- m0_awvalid  input  1  AW request from master 0 (mux in1).
- m1_awvalid  input  1  AW request from master 1 (mux in2).
- s_awready  input  1  AWREADY from slave.
- s_awlen  input  LEN_W  AWLEN at the mux output.
- s_wvalid  input  1  WVALID at the mux output.
- s_wready  input  1  WREADY from slave.
- s_wlast  input  1  WLAST at the mux output.
- mux_sel  output  1  to Mux_2x1_en sel; 0 selects master 0, 1 selects master 1.
- mux_enable  output  1  to Mux_2x1_en enable; 0 forces mux outputs to 0.
- m0_awready  output  1  equals mux_enable & ~mux_sel & s_awready & (state==ADDR).
- m1_awready  output  1  equals mux_enable & mux_sel & s_awready & (state==ADDR).
- m0_wready  output  1  equals mux_enable & ~mux_sel & s_wready & (state==DATA).
- m1_wready  output  1  equals mux_enable & mux_sel & s_wready & (state==DATA).
- len_err  output  1  one-cycle pulse on a burst length mismatch.

Behaviour:
- Reset (ARESETN low at a rising edge):
  - state=IDLE, mux_enable=0, mux_sel=0, rr_last=1 (master 0 wins first), beat_cnt=0, len_cap=0, len_err=0.
  - Reset mid-burst aborts the burst immediately; no error is flagged.
- States: IDLE, ADDR, DATA. mux_sel, mux_enable and len_err are registered; the ready outputs are combinational from registered state.
- IDLE:
  - mux_enable=0.
  - One requester asserted: grant it.
  - Both asserted: grant ~rr_last.
  - None asserted: stay in IDLE.
  - On a grant: mux_sel=granted index, mux_enable=1, rr_last=granted index, go to ADDR. The grant is visible the cycle after the request is sampled (1-cycle arbitration latency).
- ADDR:
  - Hold sel/enable.
  - On an AW handshake (granted awvalid & s_awready): len_cap=s_awlen, beat_cnt=0, go to DATA.
  - The other master's requests are ignored.
- DATA:
  - Each W handshake (s_wvalid & s_wready) increments beat_cnt, saturating at 2^LEN_W-1.
  - Handshake with s_wlast=1: go to IDLE and set mux_enable=0 on the next cycle.
  - len_err=1 for one cycle after that beat if beat_cnt != len_cap.
  - Handshake with s_wlast=0 and beat_cnt==len_cap: len_err pulses; the burst continues until WLAST.
- Bubble: there is one IDLE cycle between bursts. A burst ending while both masters request hands the grant to the other master.
- The grant never changes outside IDLE. mux_sel holds its last value while mux_enable=0.
- awvalid deasserted in ADDR (protocol violation): remain in ADDR; no timeout.

Test Plan:
1. Reset: hold ARESETN=0 for 2 cycles with both awvalid=1 -> mux_enable=0, mux_sel=0, all readys 0, len_err=0. Release reset -> mux_enable=1, mux_sel=0 on the next edge.
2. Single burst M1, AWLEN=3, 4 W beats with WLAST on beat 4 -> mux_sel=1 from grant to end, m1_wready follows s_wready, len_err stays 0, mux_enable=0 one cycle after the last beat.
3. Fairness: both masters request continuously with AWLEN=0 single-beat bursts -> grants alternate 0,1,0,1 over 4 bursts, with one IDLE cycle between each.
4. Short burst: AWLEN=3, WLAST on beat 2 -> one len_err pulse the cycle after beat 2; return to IDLE.
5. Long burst: AWLEN=1, WLAST on beat 3 -> len_err pulse after beat 2; grant held until beat 3; no second pulse.
6. Reset mid-DATA: assert ARESETN=0 after beat 1 of an AWLEN=7 burst -> IDLE next edge, readys 0, no len_err; a fresh request afterwards grants master 0.
